// File: rtl/mul_seq_ctrl.sv
// Sequencer for a repeated-addition multiplier datapath: loads A and B over a
// shared bus, clears P, then strobes P <= P + A / B <= B - 1 until eqz, with an iteration guard.
module mul_seq_ctrl #(
   parameter int WIDTH    = 16,
   parameter int MAX_ITER = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             eqz,
   output logic [WIDTH-1:0] d_bus,
   output logic             lda,
   output logic             ldb,
   output logic             clrp,
   output logic             ldp,
   output logic             decb,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      ACCUM  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_ITER);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             err_q;
   logic             at_limit;

   // iter_cnt never passes MAX_CNT, so equality is the "not below limit" test
   assign at_limit = (iter_cnt == MAX_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         iter_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q      <= op_a;
                  b_q      <= op_b;
                  iter_cnt <= '0;
                  err_q    <= 1'b0;
               end
            end
            ACCUM: begin
               if (!eqz && !at_limit) begin
                  iter_cnt <= iter_cnt + 1'b1;
               end else if (!eqz) begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      d_bus     = '0;
      lda       = 1'b0;
      ldb       = 1'b0;
      clrp      = 1'b0;
      ldp       = 1'b0;
      decb      = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LOAD_A;
         end
         LOAD_A: begin
            lda       = 1'b1;
            d_bus     = a_q;
            state_nxt = LOAD_B;
         end
         LOAD_B: begin
            ldb       = 1'b1;
            clrp      = 1'b1;
            d_bus     = b_q;
            state_nxt = ACCUM;
         end
         ACCUM: begin
            if (!eqz && !at_limit) begin
               ldp  = 1'b1;
               decb = 1'b1;
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            err       = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset silences the datapath in the very cycle it is asserted
      if (rst) begin
         d_bus = '0;
         lda   = 1'b0;
         ldb   = 1'b0;
         clrp  = 1'b0;
         ldp   = 1'b0;
         decb  = 1'b0;
         busy  = 1'b0;
         done  = 1'b0;
         err   = 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a small A/B/P datapath model closes the eqz loop and
// every operation is checked cycle by cycle against the expected strobe schedule.
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, start2;
   logic [15:0] op_a, op_b, op_a2, op_b2;
   logic        eqz;
   logic [15:0] d_bus, iter_cnt, d_bus2, iter_cnt2;
   logic        lda, ldb, clrp, ldp, decb, busy, done, err;
   logic        lda2, ldb2, clrp2, ldp2, decb2, busy2, done2, err2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_seq_ctrl #(.WIDTH(16), .MAX_ITER(65535)) u_dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .eqz(eqz),
      .d_bus(d_bus), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
      .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
   );

   mul_seq_ctrl #(.WIDTH(16), .MAX_ITER(3)) u_lim (
      .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2), .eqz(1'b0),
      .d_bus(d_bus2), .lda(lda2), .ldb(ldb2), .clrp(clrp2), .ldp(ldp2), .decb(decb2),
      .busy(busy2), .done(done2), .err(err2), .iter_cnt(iter_cnt2)
   );

   // Datapath model driven by the sequencer strobes
   logic [15:0] a_reg = '0, b_reg = '0, p_reg = '0;
   assign eqz = (b_reg == 16'd0);
   always @(posedge clk) begin
      if (lda) a_reg <= d_bus;
      if (ldb) b_reg <= d_bus;
      else if (decb) b_reg <= b_reg - 16'd1;
      if (clrp) p_reg <= '0;
      else if (ldp) p_reg <= p_reg + a_reg;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] late_a, input bit pulses, input bit hold);
      int          n;
      logic [31:0] full;
      n    = int'(b);
      full = 32'(a) * 32'(b);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      for (int k = 1; k <= n + 4; k++) begin
         cyc();
         chk1("lda",  lda,  k == 1);
         chk1("ldb",  ldb,  k == 2);
         chk1("clrp", clrp, k == 2);
         chk1("ldp",  ldp,  k >= 3 && k <= n + 2);
         chk1("decb", decb, k >= 3 && k <= n + 2);
         chk1("done", done, k == n + 4);
         chk1("busy", busy, 1'b1);
         chk1("err",  err,  1'b0);
         if (k == 1) chk16("d_bus_a", d_bus, a);
         if (k == 2) chk16("d_bus_b", d_bus, b);
         if (k == n + 4) begin
            chk16("iter_cnt", iter_cnt, b);
            chk16("product", p_reg, full[15:0]);
         end
         if (k == 1) begin
            op_a = late_a;
            op_b = ~b;
         end
         start = (pulses && (k == 2 || k == 5)) || (hold && k == n + 4);
      end
      cyc();
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_done", done, 1'b0);
      chk1("idle_lda",  lda,  1'b0);
      chk16("iter_hold", iter_cnt, b);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; start2 = 1'b0;
      op_a = 16'h1234; op_b = 16'h0003; op_a2 = '0; op_b2 = '0;
      cyc();
      cyc();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_lda",  lda,  1'b0);
      chk1("rst_done", done, 1'b0);
      chk16("rst_iter", iter_cnt, 16'd0);
      rst = 1'b0; start = 1'b0;
      cyc();
      chk1("no_start_after_rst", busy, 1'b0);

      // Basic multiply, then ignored pulses and a held start
      run_op(16'd7, 16'd5, 16'hBEEF, 1'b0, 1'b0);
      chk16("p_7x5", p_reg, 16'd35);
      run_op(16'd9, 16'd0, 16'h0001, 1'b0, 1'b0);
      chk16("p_bzero", p_reg, 16'd0);
      run_op(16'd7, 16'd5, 16'h0000, 1'b1, 1'b1);
      chk1("held_start_lda_next", lda, 1'b0);
      run_op(16'd6, 16'd3, 16'h0002, 1'b0, 1'b0);
      run_op(16'h0012, 16'd2, 16'hFFFF, 1'b0, 1'b0);
      start = 1'b0;

      // Iteration guard with eqz stuck low
      op_a2 = 16'd1; op_b2 = 16'd9; start2 = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         start2 = 1'b0;
         chk1("lim_ldp",  ldp2,  k >= 3 && k <= 5);
         chk1("lim_decb", decb2, k >= 3 && k <= 5);
         chk1("lim_done", done2, k == 7);
         chk1("lim_err",  err2,  k == 7);
      end
      chk16("lim_iter", iter_cnt2, 16'd3);
      cyc();
      chk1("lim_err_idle", err2, 1'b0);
      chk1("lim_busy_idle", busy2, 1'b0);

      // Reset in the middle of an operation
      op_a = 16'd2; op_b = 16'd9; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk1("mid_rst_ldp",  ldp,  1'b0);
      chk1("mid_rst_decb", decb, 1'b0);
      chk1("mid_rst_busy", busy, 1'b0);
      cyc();
      chk1("post_rst_busy", busy, 1'b0);
      chk16("post_rst_iter", iter_cnt, 16'd0);
      chk1("post_rst_done", done, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk1("no_done_after_rst", done, 1'b0);
      end
      run_op(16'd3, 16'd4, 16'h7777, 1'b0, 1'b0);
      chk16("p_3x4", p_reg, 16'd12);

      // Randomized operations
      for (int i = 0; i < 8; i++) begin
         logic [15:0] ra, rb, rl;
         ra = 16'($urandom);
         rb = 16'($urandom_range(0, 12));
         rl = 16'($urandom);
         run_op(ra, rb, rl, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
